// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/cache bundle for the multicycle MIPS core.
// The master side is the control unit; the slave side is the datapath/caches.
// aluop carries the 4-bit cpu_types_pkg::aluop_t encoding.
interface multicycle_control_unit_if #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [WORD_W-1:0] instr;
  logic              ihit;
  logic              dhit;
  logic              zero;
  logic              iREN;
  logic              dREN;
  logic              dWEN;
  logic              irWEN;
  logic              pcWEN;
  logic [1:0]        pcsrc;
  logic [3:0]        aluop;
  logic              alusrc;
  logic [1:0]        extop;
  logic              regWEN;
  logic [REG_AW-1:0] wsel;
  logic [1:0]        memtoreg;
  logic              halt;
  logic              err;
  logic [2:0]        state;
  logic [CNT_W-1:0]  icount;

  modport master (
    input  instr, ihit, dhit, zero,
    output iREN, dREN, dWEN, irWEN, pcWEN, pcsrc, aluop, alusrc, extop,
           regWEN, wsel, memtoreg, halt, err, state, icount
  );

  modport slave (
    output instr, ihit, dhit, zero,
    input  iREN, dREN, dWEN, irWEN, pcWEN, pcsrc, aluop, alusrc, extop,
           regWEN, wsel, memtoreg, halt, err, state, icount
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Sequenced control unit for the multicycle MIPS datapath: FETCH, DECODE,
// EXEC, MEM, WB with cache handshakes, optional watchdog, retired-instruction
// counter and sticky HALT/ERROR states.
package cpu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module multicycle_control_unit #(
  parameter int          WORD_W  = 32,
  parameter int          REG_AW  = 5,
  parameter int unsigned TIMEOUT = 0,
  parameter int          CNT_W   = 32
) (
  input  logic                        CLK,
  input  logic                        nRST,
  multicycle_control_unit_if.master   bus
);
  import cpu_types_pkg::*;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Last wait-count value still allowed without a hit (0 when watchdog is off).
  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_t            state_q, state_d;
  logic [31:0]       wait_q, wait_d;
  logic [CNT_W-1:0]  icount_q, icount_d;
  logic              err_q, err_d;

  // Instruction fields and decode results
  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rt_s, rd_s;
  logic        dec_valid_s, is_rtype_s, is_jr_s, is_j_s, is_jal_s, is_halt_s;
  logic        is_beq_s, is_bne_s, is_lw_s, is_sw_s;
  aluop_t      dec_aluop_s;
  logic        dec_alusrc_s;
  logic [1:0]  dec_extop_s;
  logic        unused_instr_s;

  // Handshakes are ignored while reset is held so no strobe escapes
  logic        ihit_s, dhit_s, timeout_s;

  // Control outputs
  logic        iren_s, dren_s, dwen_s, irwen_s, pcwen_s, alusrc_s, regwen_s;
  logic [1:0]  pcsrc_s, extop_s, memtoreg_s;
  aluop_t      aluop_s;
  logic [REG_AW-1:0] wsel_s;

  assign opcode_s       = bus.instr[31:26];
  assign rt_s           = bus.instr[20:16];
  assign rd_s           = bus.instr[15:11];
  assign funct_s        = bus.instr[5:0];
  assign unused_instr_s = ^bus.instr;

  assign ihit_s    = bus.ihit & nRST;
  assign dhit_s    = bus.dhit & nRST;
  assign timeout_s = (TIMEOUT != 0) && (wait_q == TO_LAST);

  // Instruction decode: classify instr and pick its ALU controls
  always_comb begin
    dec_valid_s  = 1'b1;
    is_rtype_s   = 1'b0;
    is_jr_s      = 1'b0;
    is_j_s       = 1'b0;
    is_jal_s     = 1'b0;
    is_halt_s    = 1'b0;
    is_beq_s     = 1'b0;
    is_bne_s     = 1'b0;
    is_lw_s      = 1'b0;
    is_sw_s      = 1'b0;
    dec_aluop_s  = ALU_ADD;
    dec_alusrc_s = 1'b1;
    dec_extop_s  = 2'd1;
    case (opcode_s)
      OP_RTYPE: begin
        is_rtype_s   = 1'b1;
        dec_alusrc_s = 1'b0;
        case (funct_s)
          FN_ADDU: dec_aluop_s = ALU_ADD;
          FN_SUBU: dec_aluop_s = ALU_SUB;
          FN_AND:  dec_aluop_s = ALU_AND;
          FN_OR:   dec_aluop_s = ALU_OR;
          FN_SLT:  dec_aluop_s = ALU_SLT;
          FN_JR:   is_jr_s     = 1'b1;
          default: dec_valid_s = 1'b0;
        endcase
      end
      OP_J:     is_j_s    = 1'b1;
      OP_JAL:   is_jal_s  = 1'b1;
      OP_HALT:  is_halt_s = 1'b1;
      OP_BEQ: begin
        is_beq_s     = 1'b1;
        dec_aluop_s  = ALU_SUB;
        dec_alusrc_s = 1'b0;
      end
      OP_BNE: begin
        is_bne_s     = 1'b1;
        dec_aluop_s  = ALU_SUB;
        dec_alusrc_s = 1'b0;
      end
      OP_ADDIU: dec_aluop_s = ALU_ADD;
      OP_ORI: begin
        dec_aluop_s = ALU_OR;
        dec_extop_s = 2'd0;
      end
      OP_LUI: begin
        dec_aluop_s = ALU_ADD;
        dec_extop_s = 2'd2;
      end
      OP_LW:    is_lw_s = 1'b1;
      OP_SW:    is_sw_s = 1'b1;
      default:  dec_valid_s = 1'b0;
    endcase
  end

  // FSM next-state and per-state control strobes
  always_comb begin
    state_d    = state_q;
    iren_s     = 1'b0;
    dren_s     = 1'b0;
    dwen_s     = 1'b0;
    irwen_s    = 1'b0;
    pcwen_s    = 1'b0;
    pcsrc_s    = 2'd0;
    aluop_s    = ALU_ADD;
    alusrc_s   = 1'b0;
    extop_s    = 2'd0;
    regwen_s   = 1'b0;
    wsel_s     = '0;
    memtoreg_s = 2'd0;
    case (state_q)
      S_FETCH: begin
        iren_s = 1'b1;
        if (ihit_s) begin
          irwen_s = 1'b1;
          pcwen_s = 1'b1;
          pcsrc_s = 2'd0;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!dec_valid_s) begin
          state_d = S_ERROR;
        end else if (is_halt_s) begin
          state_d = S_HALT;
        end else if (is_j_s) begin
          pcwen_s = 1'b1;
          pcsrc_s = 2'd2;
          state_d = S_FETCH;
        end else if (is_jal_s) begin
          pcwen_s    = 1'b1;
          pcsrc_s    = 2'd2;
          regwen_s   = 1'b1;
          wsel_s     = REG_AW'(5'd31);
          memtoreg_s = 2'd2;
          state_d    = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluop_s  = dec_aluop_s;
        alusrc_s = dec_alusrc_s;
        extop_s  = dec_extop_s;
        if (is_beq_s) begin
          pcwen_s = bus.zero;
          pcsrc_s = 2'd1;
          state_d = S_FETCH;
        end else if (is_bne_s) begin
          pcwen_s = ~bus.zero;
          pcsrc_s = 2'd1;
          state_d = S_FETCH;
        end else if (is_jr_s) begin
          pcwen_s = 1'b1;
          pcsrc_s = 2'd3;
          state_d = S_FETCH;
        end else if (is_lw_s || is_sw_s) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Address computation stays valid while the cache is busy
        aluop_s  = dec_aluop_s;
        alusrc_s = dec_alusrc_s;
        extop_s  = dec_extop_s;
        if (is_lw_s) begin
          dren_s = 1'b1;
          if (dhit_s) begin
            irwen_s = 1'b1;
            state_d = S_WB;
          end else if (timeout_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_MEM;
          end
        end else if (is_sw_s) begin
          dwen_s = 1'b1;
          if (dhit_s) begin
            state_d = S_FETCH;
          end else if (timeout_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_MEM;
          end
        end else begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        // ALU result must still be valid for non-load writebacks
        aluop_s    = dec_aluop_s;
        alusrc_s   = dec_alusrc_s;
        extop_s    = dec_extop_s;
        regwen_s   = 1'b1;
        wsel_s     = is_rtype_s ? REG_AW'(rd_s) : REG_AW'(rt_s);
        memtoreg_s = is_lw_s ? 2'd1 : 2'd0;
        state_d    = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Watchdog wait counter, retired-instruction counter and sticky error
  always_comb begin
    wait_d   = 32'd0;
    icount_d = icount_q;
    err_d    = err_q | (state_d == S_ERROR);
    if (state_d != state_q) begin
      wait_d = 32'd0;
    end else if ((state_q == S_FETCH && !ihit_s) || (state_q == S_MEM && !dhit_s)) begin
      wait_d = wait_q + 32'd1;
    end else begin
      wait_d = 32'd0;
    end
    if (state_d == S_FETCH && (state_q == S_DECODE || state_q == S_EXEC ||
                               state_q == S_MEM || state_q == S_WB)) begin
      icount_d = icount_q + CNT_W'(1);
    end else begin
      icount_d = icount_q;
    end
  end

  // State and counter registers with asynchronous abort on reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_FETCH;
      wait_q   <= 32'd0;
      icount_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      icount_q <= icount_d;
      err_q    <= err_d;
    end
  end

  assign bus.iREN     = iren_s;
  assign bus.dREN     = dren_s;
  assign bus.dWEN     = dwen_s;
  assign bus.irWEN    = irwen_s;
  assign bus.pcWEN    = pcwen_s;
  assign bus.pcsrc    = pcsrc_s;
  assign bus.aluop    = aluop_s;
  assign bus.alusrc   = alusrc_s;
  assign bus.extop    = extop_s;
  assign bus.regWEN   = regwen_s;
  assign bus.wsel     = wsel_s;
  assign bus.memtoreg = memtoreg_s;
  assign bus.halt     = (state_q == S_HALT) || (state_q == S_ERROR);
  assign bus.err      = err_q;
  assign bus.state    = state_q;
  assign bus.icount   = icount_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with TIMEOUT=4.
module tb_multicycle_control_unit;
  import cpu_types_pkg::*;

  localparam logic [31:0] I_ADDU  = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] I_LW    = 32'h8C85_0004; // lw   $5,4($4)
  localparam logic [31:0] I_BEQ   = 32'h1022_0003; // beq  $1,$2,3
  localparam logic [31:0] I_BNE   = 32'h1422_0003; // bne  $1,$2,3
  localparam logic [31:0] I_JAL   = 32'h0C00_0100; // jal  0x100
  localparam logic [31:0] I_HALT  = 32'hFC00_0000; // halt
  localparam logic [31:0] I_ADDIU = 32'h2406_0001; // addiu $6,$0,1
  localparam logic [31:0] I_LUI   = 32'h3C07_1234; // lui  $7,0x1234
  localparam logic [31:0] I_SW    = 32'hAC85_0008; // sw   $5,8($4)
  localparam logic [31:0] I_BAD   = 32'h0400_0000; // opcode 0x01

  logic CLK;
  logic nRST;
  int   n_tests;
  int   n_fail;

  multicycle_control_unit_if #(.WORD_W(32), .REG_AW(5), .CNT_W(32)) bus();

  multicycle_control_unit #(.WORD_W(32), .REG_AW(5), .TIMEOUT(4), .CNT_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    settle();
    @(posedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    nRST       = 1'b1;
    bus.instr  = 32'd0;
    bus.ihit   = 1'b0;
    bus.dhit   = 1'b0;
    bus.zero   = 1'b0;
    #1;
    nRST = 1'b0;
    settle();
    check("rst_state",  32'(bus.state),  32'd0);
    check("rst_iREN",   32'(bus.iREN),   32'd1);
    check("rst_halt",   32'(bus.halt),   32'd0);
    check("rst_err",    32'(bus.err),    32'd0);
    check("rst_icount", bus.icount,      32'd0);
    check("rst_regWEN", 32'(bus.regWEN), 32'd0);
    check("rst_dREN",   32'(bus.dREN),   32'd0);
    check("rst_dWEN",   32'(bus.dWEN),   32'd0);
    bus.ihit = 1'b1;
    settle();
    check("rst_ihit_irWEN", 32'(bus.irWEN), 32'd0);
    check("rst_ihit_pcWEN", 32'(bus.pcWEN), 32'd0);
    bus.ihit = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    nRST = 1'b1;

    // Fetch with ihit arriving on the fourth cycle (watchdog boundary)
    settle();
    check("f1_iREN",  32'(bus.iREN),  32'd1);
    check("f1_irWEN", 32'(bus.irWEN), 32'd0);
    tick(); settle();
    check("f2_iREN",  32'(bus.iREN),  32'd1);
    check("f2_pcWEN", 32'(bus.pcWEN), 32'd0);
    tick(); settle();
    check("f3_iREN",  32'(bus.iREN),  32'd1);
    tick();
    bus.ihit  = 1'b1;
    bus.instr = I_ADDU;
    settle();
    check("f4_state", 32'(bus.state), 32'd0);
    check("f4_iREN",  32'(bus.iREN),  32'd1);
    check("f4_irWEN", 32'(bus.irWEN), 32'd1);
    check("f4_pcWEN", 32'(bus.pcWEN), 32'd1);
    check("f4_pcsrc", 32'(bus.pcsrc), 32'd0);
    tick();
    bus.ihit = 1'b0;

    // ADDU $3,$1,$2
    settle();
    check("addu_dec_state",  32'(bus.state),  32'd1);
    check("addu_dec_regWEN", 32'(bus.regWEN), 32'd0);
    check("addu_dec_iREN",   32'(bus.iREN),   32'd0);
    tick(); settle();
    check("addu_ex_state",  32'(bus.state),  32'd2);
    check("addu_ex_aluop",  32'(bus.aluop),  32'(ALU_ADD));
    check("addu_ex_alusrc", 32'(bus.alusrc), 32'd0);
    check("addu_ex_regWEN", 32'(bus.regWEN), 32'd0);
    tick(); settle();
    check("addu_wb_state",    32'(bus.state),    32'd4);
    check("addu_wb_regWEN",   32'(bus.regWEN),   32'd1);
    check("addu_wb_wsel",     32'(bus.wsel),     32'd3);
    check("addu_wb_memtoreg", 32'(bus.memtoreg), 32'd0);
    check("addu_wb_icount",   bus.icount,        32'd0);
    tick(); settle();
    check("addu_done_state",  32'(bus.state),  32'd0);
    check("addu_done_regWEN", 32'(bus.regWEN), 32'd0);
    check("addu_done_icount", bus.icount,      32'd1);

    // LW $5,4($4) with dhit on the third MEM cycle
    bus.ihit = 1'b1; bus.instr = I_LW;
    tick();
    bus.ihit = 1'b0;
    tick(); settle();
    check("lw_ex_state", 32'(bus.state), 32'd2);
    check("lw_ex_extop", 32'(bus.extop), 32'd1);
    check("lw_ex_alusrc", 32'(bus.alusrc), 32'd1);
    tick(); settle();
    check("lw_m1_state", 32'(bus.state), 32'd3);
    check("lw_m1_dREN",  32'(bus.dREN),  32'd1);
    check("lw_m1_dWEN",  32'(bus.dWEN),  32'd0);
    check("lw_m1_irWEN", 32'(bus.irWEN), 32'd0);
    check("lw_m1_aluop", 32'(bus.aluop), 32'(ALU_ADD));
    tick(); settle();
    check("lw_m2_dREN",  32'(bus.dREN),  32'd1);
    check("lw_m2_state", 32'(bus.state), 32'd3);
    tick();
    bus.dhit = 1'b1;
    settle();
    check("lw_m3_dREN",  32'(bus.dREN),  32'd1);
    check("lw_m3_dWEN",  32'(bus.dWEN),  32'd0);
    check("lw_m3_irWEN", 32'(bus.irWEN), 32'd1);
    tick();
    bus.dhit = 1'b0;
    settle();
    check("lw_wb_state",    32'(bus.state),    32'd4);
    check("lw_wb_regWEN",   32'(bus.regWEN),   32'd1);
    check("lw_wb_wsel",     32'(bus.wsel),     32'd5);
    check("lw_wb_memtoreg", 32'(bus.memtoreg), 32'd1);
    check("lw_wb_dREN",     32'(bus.dREN),     32'd0);
    tick(); settle();
    check("lw_done_icount", bus.icount, 32'd2);

    // BEQ taken, BNE not taken with zero=1
    bus.ihit = 1'b1; bus.instr = I_BEQ;
    tick();
    bus.ihit = 1'b0;
    tick();
    bus.zero = 1'b1;
    settle();
    check("beq_ex_state", 32'(bus.state), 32'd2);
    check("beq_ex_pcWEN", 32'(bus.pcWEN), 32'd1);
    check("beq_ex_pcsrc", 32'(bus.pcsrc), 32'd1);
    check("beq_ex_aluop", 32'(bus.aluop), 32'(ALU_SUB));
    tick(); settle();
    check("beq_done_state",  32'(bus.state), 32'd0);
    check("beq_done_icount", bus.icount,     32'd3);
    bus.ihit = 1'b1; bus.instr = I_BNE;
    tick();
    bus.ihit = 1'b0;
    tick(); settle();
    check("bne_z1_pcWEN", 32'(bus.pcWEN), 32'd0);
    check("bne_z1_pcsrc", 32'(bus.pcsrc), 32'd1);
    bus.zero = 1'b0;
    settle();
    check("bne_z0_pcWEN", 32'(bus.pcWEN), 32'd1);
    tick(); settle();
    check("bne_done_state",  32'(bus.state), 32'd0);
    check("bne_done_icount", bus.icount,     32'd4);

    // JAL 0x100
    bus.ihit = 1'b1; bus.instr = I_JAL;
    tick();
    bus.ihit = 1'b0;
    settle();
    check("jal_dec_state",    32'(bus.state),    32'd1);
    check("jal_dec_pcWEN",    32'(bus.pcWEN),    32'd1);
    check("jal_dec_pcsrc",    32'(bus.pcsrc),    32'd2);
    check("jal_dec_regWEN",   32'(bus.regWEN),   32'd1);
    check("jal_dec_wsel",     32'(bus.wsel),     32'd31);
    check("jal_dec_memtoreg", 32'(bus.memtoreg), 32'd2);
    tick(); settle();
    check("jal_done_state",  32'(bus.state), 32'd0);
    check("jal_done_icount", bus.icount,     32'd5);

    // Watchdog: ihit never arrives, ERROR after four FETCH cycles
    tick(); settle();
    check("wd_f2_state", 32'(bus.state), 32'd0);
    tick(); settle();
    check("wd_f3_state", 32'(bus.state), 32'd0);
    tick(); settle();
    check("wd_f4_state", 32'(bus.state), 32'd0);
    check("wd_f4_err",   32'(bus.err),   32'd0);
    tick(); settle();
    check("wd_state",  32'(bus.state), 32'd6);
    check("wd_halt",   32'(bus.halt),  32'd1);
    check("wd_err",    32'(bus.err),   32'd1);
    check("wd_iREN",   32'(bus.iREN),  32'd0);
    check("wd_icount", bus.icount,     32'd5);
    bus.ihit = 1'b1;
    settle();
    check("wd_hit_irWEN", 32'(bus.irWEN), 32'd0);
    tick(); settle();
    check("wd_sticky_state", 32'(bus.state), 32'd6);
    bus.ihit = 1'b0;

    // HALT opcode
    do_reset();
    settle();
    check("rst2_err",    32'(bus.err), 32'd0);
    check("rst2_icount", bus.icount,   32'd0);
    bus.ihit = 1'b1; bus.instr = I_HALT;
    tick();
    bus.ihit = 1'b0;
    tick(); settle();
    check("halt_state",  32'(bus.state), 32'd5);
    check("halt_halt",   32'(bus.halt),  32'd1);
    check("halt_err",    32'(bus.err),   32'd0);
    check("halt_iREN",   32'(bus.iREN),  32'd0);
    check("halt_icount", bus.icount,     32'd0);
    tick(); settle();
    check("halt_sticky", 32'(bus.state), 32'd5);

    // ADDIU, LUI, then SW aborted by reset in MEM
    do_reset();
    bus.ihit = 1'b1; bus.instr = I_ADDIU;
    tick();
    bus.ihit = 1'b0;
    tick(); settle();
    check("addiu_ex_extop",  32'(bus.extop),  32'd1);
    check("addiu_ex_alusrc", 32'(bus.alusrc), 32'd1);
    tick(); settle();
    check("addiu_wb_wsel",     32'(bus.wsel),     32'd6);
    check("addiu_wb_memtoreg", 32'(bus.memtoreg), 32'd0);
    tick();
    bus.ihit = 1'b1; bus.instr = I_LUI;
    tick();
    bus.ihit = 1'b0;
    tick(); settle();
    check("lui_ex_extop", 32'(bus.extop), 32'd2);
    tick(); settle();
    check("lui_wb_wsel", 32'(bus.wsel), 32'd7);
    tick(); settle();
    check("lui_done_icount", bus.icount, 32'd2);
    bus.ihit = 1'b1; bus.instr = I_SW;
    tick();
    bus.ihit = 1'b0;
    tick(); tick(); settle();
    check("sw_m_state", 32'(bus.state), 32'd3);
    check("sw_m_dWEN",  32'(bus.dWEN),  32'd1);
    check("sw_m_dREN",  32'(bus.dREN),  32'd0);
    nRST = 1'b0;
    settle();
    check("abort_state",  32'(bus.state), 32'd0);
    check("abort_dWEN",   32'(bus.dWEN),  32'd0);
    check("abort_icount", bus.icount,     32'd0);
    check("abort_iREN",   32'(bus.iREN),  32'd1);
    @(posedge CLK);
    #2;
    nRST = 1'b1;

    // Unsupported opcode leaves DECODE into ERROR
    bus.ihit = 1'b1; bus.instr = I_BAD;
    tick();
    bus.ihit = 1'b0;
    settle();
    check("bad_dec_state", 32'(bus.state), 32'd1);
    tick(); settle();
    check("bad_state", 32'(bus.state), 32'd6);
    check("bad_err",   32'(bus.err),   32'd1);
    check("bad_halt",  32'(bus.halt),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequenced control unit for the multicycle MIPS datapath. It replaces single-cycle combinational decode with a state machine that splits each instruction into fetch, decode, execute, memory and writeback.
- It handshakes with the instruction and data caches via ihit/dhit, with a parametrised watchdog timeout on each.
- It counts retired instructions and stops in sticky HALT or ERROR states.

Parameters:
- WORD_W, 32, instruction/data word width
- REG_AW, 5, register-file select width
- TIMEOUT, 0, max wait cycles for ihit/dhit before ERROR; 0 disables the watchdog
- CNT_W, 32, width of the retired-instruction counter

Ports:
- CLK in 1 system clock, rising edge
- nRST in 1 asynchronous active-low reset
- instr in WORD_W instruction from the external IR, stable after irWEN
- ihit in 1 instruction cache returned data this cycle
- dhit in 1 data cache completed access this cycle
- zero in 1 ALU zero flag
- iREN out 1 instruction read request
- dREN out 1 data read request
- dWEN out 1 data write request
- irWEN out 1 load IR (and MDR for LW)
- pcWEN out 1 PC update strobe
- pcsrc out 2 0=PC+4, 1=branch target, 2=jump target, 3=rs (JR)
- aluop out aluop_t operation selected from the cpu_types_pkg encoding
- alusrc out 1 0=rt, 1=extended immediate
- extop out 2 0=zero-ext, 1=sign-ext, 2=LUI (imm<<16)
- regWEN out 1 register write enable
- wsel out REG_AW destination register
- memtoreg out 2 0=ALU, 1=MDR, 2=PC+4
- halt out 1 sticky halt (HALT or ERROR)
- err out 1 sticky error
- state out 3 current state, for debug
- icount out CNT_W retired-instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERROR=6. Encoding 7 is unreachable and goes to ERROR.
- Reset (nRST=0, asynchronous): state=FETCH, wait counter=0, icount=0, err=0. Outputs during and immediately after reset are iREN=1, halt=0, and all other strobes 0.
- Outputs are combinational from state, the decoded instr, ihit/dhit and zero. Only state, the wait counter, icount and err are registered.
- Decoded instruction set:
  - R-type funct: ADDU, SUBU, AND, OR, SLT, JR.
  - I-type and J-type: ADDIU, ORI, LUI, LW, SW, BEQ, BNE, J, JAL, HALT (opcode 0x3F).
  - Any other opcode or funct causes ERROR on leaving DECODE.
- FETCH:
  - iREN=1.
  - When ihit=1: irWEN=1, pcWEN=1, pcsrc=0, then go to DECODE.
  - When ihit=0: stay in FETCH.
- DECODE:
  - HALT goes to HALT.
  - J: pcWEN=1, pcsrc=2, then FETCH.
  - JAL: pcWEN=1, pcsrc=2, regWEN=1, wsel=31, memtoreg=2, then FETCH.
  - Unsupported instruction goes to ERROR.
  - Everything else goes to EXEC.
- EXEC:
  - aluop and alusrc are driven per instruction. extop=1 for ADDIU, LW, SW, BEQ, BNE; extop=0 for ORI; extop=2 for LUI.
  - BEQ: pcWEN=zero, pcsrc=1, then FETCH.
  - BNE: pcWEN=!zero, pcsrc=1, then FETCH.
  - JR: pcWEN=1, pcsrc=3, then FETCH.
  - LW/SW go to MEM; all others go to WB.
- MEM:
  - dREN=1 for LW, dWEN=1 for SW. The ALU controls from EXEC are held.
  - LW with dhit: irWEN=1 (MDR load), then WB.
  - SW with dhit: go to FETCH.
  - dREN and dWEN are never both asserted.
- WB:
  - regWEN=1 for exactly one cycle, then FETCH.
  - wsel=rd for R-type and rt for I-type; memtoreg=1 for LW, else 0.
- Wait counter:
  - Increments each FETCH or MEM cycle with no hit.
  - Clears on any state change and on hit.
  - If TIMEOUT>0 and the count equals TIMEOUT-1 with no hit: go to ERROR on the next edge.
  - A hit in the same cycle as the timeout has priority; no error is raised.
- icount increments by 1 on each transition into FETCH from DECODE, EXEC, MEM or WB. It wraps modulo 2^CNT_W and does not increment on reset.
- HALT: halt=1 and all strobes 0. The state is held until nRST.
- ERROR: halt=1 and err=1, all strobes 0. The state is held until nRST.
- Reset asserted mid-instruction aborts immediately. No register or memory write completes after nRST falls.

Test Plan:
- Reset release, then ihit=1 after 3 cycles -> iREN high for 4 cycles, with a single irWEN/pcWEN pulse on the hit cycle; state goes 0→1.
- ADDU $3,$1,$2 with hits every cycle -> states FETCH, DECODE, EXEC, WB, FETCH; exactly one regWEN cycle with wsel=3, memtoreg=0; icount 0→1.
- LW $5,4($4) with dhit delayed 2 cycles -> dREN high for 3 MEM cycles, then irWEN, then WB with regWEN=1, wsel=5, memtoreg=1; dWEN stays 0.
- BEQ with zero=1, then BNE with zero=1 -> first gives pcWEN=1, pcsrc=1 in EXEC; second gives pcWEN=0; each takes 3 cycles.
- JAL 0x100 -> in DECODE: pcWEN=1, pcsrc=2, regWEN=1, wsel=31, memtoreg=2; next state FETCH.
- TIMEOUT=4 with ihit never asserted -> ERROR after 4 FETCH cycles, halt=1, err=1. Repeat with ihit on cycle 4 -> no error. HALT opcode -> state 5, halt=1, err=0; nRST low mid-MEM -> state=FETCH, icount=0.
